// File: rtl/player_grid.sv
// Grid-stepping player position tracker: level-sensitive direction inputs with
// auto-repeat, boundary refusal, right-edge wrap into the next level.
module player_grid #(
  parameter int W             = 10,
  parameter int STEP          = 40,
  parameter int H_START       = 40,
  parameter int V_START       = 240,
  parameter int H_LIMIT       = 640,
  parameter int V_LIMIT       = 480,
  parameter int REPEAT_CYCLES = 4,
  parameter int LW            = 4,
  parameter int MAX_LEVEL     = 15
) (
  input  logic          clk,
  input  logic          reset_player_n,
  input  logic          restart,
  input  logic          pause,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  output logic [W-1:0]  pos_h,
  output logic [W-1:0]  pos_v,
  output logic [LW-1:0] level,
  output logic          level_up,
  output logic          game_wrap,
  output logic          moved,
  output logic          blocked
);

  localparam int RW = $clog2(REPEAT_CYCLES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic [W:0]    C_STEP     = (W+1)'(STEP);
  localparam logic [W:0]    C_HLIM     = (W+1)'(H_LIMIT);
  localparam logic [W:0]    C_VLIM     = (W+1)'(V_LIMIT);
  localparam logic [W-1:0]  C_STEP_W   = W'(STEP);
  localparam logic [W-1:0]  C_HSTART   = W'(H_START);
  localparam logic [W-1:0]  C_VSTART   = W'(V_START);
  localparam logic [LW-1:0] C_LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] C_LVL_MAX  = LW'(MAX_LEVEL);
  localparam logic [RW-1:0] C_RPT_ONE  = RW'(1);
  localparam logic [RW-1:0] C_RPT_LAST = RW'(REPEAT_CYCLES - 1);

  logic [0:0]    r_state;
  logic [RW-1:0] r_rpt;
  logic [3:0]    r_dir_q;
  logic [W-1:0]  r_pos_h;
  logic [W-1:0]  r_pos_v;
  logic [LW-1:0] r_level;
  logic          r_level_up;
  logic          r_game_wrap;
  logic          r_moved;
  logic          r_blocked;

  logic [3:0]    w_dir;
  logic          w_fire;
  logic [0:0]    w_state_nxt;
  logic [RW-1:0] w_rpt_nxt;
  logic [W:0]    w_h_ext;
  logic [W:0]    w_v_ext;
  logic [W-1:0]  w_h_nxt;
  logic [W-1:0]  w_v_nxt;
  logic          w_h_chg;
  logic          w_v_chg;
  logic          w_h_ref;
  logic          w_v_ref;
  logic          w_adv;
  logic [LW-1:0] w_lvl_nxt;
  logic          w_wrap;

  assign w_dir   = {up, down, left, right};
  assign w_h_ext = {1'b0, r_pos_h};
  assign w_v_ext = {1'b0, r_pos_v};

  // Move-event sequencing: first press, direction change, or auto-repeat expiry
  always_comb begin
    w_fire      = 1'b0;
    w_state_nxt = r_state;
    w_rpt_nxt   = r_rpt;
    if (pause) begin
      w_fire = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dir != 4'b0000) begin
            w_fire      = 1'b1;
            w_rpt_nxt   = {RW{1'b0}};
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_HOLD: begin
          if (w_dir == 4'b0000) begin
            w_state_nxt = S_IDLE;
          end else if (w_dir != r_dir_q) begin
            w_fire    = 1'b1;
            w_rpt_nxt = {RW{1'b0}};
          end else if (r_rpt == C_RPT_LAST) begin
            w_fire    = 1'b1;
            w_rpt_nxt = {RW{1'b0}};
          end else begin
            w_rpt_nxt = r_rpt + C_RPT_ONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_rpt_nxt   = {RW{1'b0}};
        end
      endcase
    end
  end

  // Vertical axis resolution; bounds compared one bit wider than the position
  always_comb begin
    w_v_nxt = r_pos_v;
    w_v_chg = 1'b0;
    w_v_ref = 1'b0;
    if (up && !down) begin
      if (w_v_ext > C_STEP) begin
        w_v_nxt = r_pos_v - C_STEP_W;
        w_v_chg = 1'b1;
      end else begin
        w_v_ref = 1'b1;
      end
    end else if (down && !up) begin
      if ((w_v_ext + C_STEP) < C_VLIM) begin
        w_v_nxt = r_pos_v + C_STEP_W;
        w_v_chg = 1'b1;
      end else begin
        w_v_ref = 1'b1;
      end
    end else begin
      w_v_nxt = r_pos_v;
    end
  end

  // Horizontal axis resolution; running off the right edge advances the level
  always_comb begin
    w_h_nxt = r_pos_h;
    w_h_chg = 1'b0;
    w_h_ref = 1'b0;
    w_adv   = 1'b0;
    if (left && !right) begin
      if (w_h_ext > C_STEP) begin
        w_h_nxt = r_pos_h - C_STEP_W;
        w_h_chg = 1'b1;
      end else begin
        w_h_ref = 1'b1;
      end
    end else if (right && !left) begin
      if ((w_h_ext + C_STEP) <= C_HLIM) begin
        w_h_nxt = r_pos_h + C_STEP_W;
        w_h_chg = 1'b1;
      end else begin
        w_h_nxt = C_HSTART;
        w_h_chg = 1'b1;
        w_adv   = 1'b1;
      end
    end else begin
      w_h_nxt = r_pos_h;
    end
  end

  // Next level value for an advance
  always_comb begin
    w_lvl_nxt = r_level;
    w_wrap    = 1'b0;
    if (r_level == C_LVL_MAX) begin
      w_lvl_nxt = C_LVL_ONE;
      w_wrap    = 1'b1;
    end else begin
      w_lvl_nxt = r_level + C_LVL_ONE;
      w_wrap    = 1'b0;
    end
  end

  // State, position, level and registered event pulses
  always_ff @(posedge clk or negedge reset_player_n) begin
    if (!reset_player_n) begin
      r_state     <= S_IDLE;
      r_rpt       <= {RW{1'b0}};
      r_dir_q     <= 4'b0000;
      r_pos_h     <= C_HSTART;
      r_pos_v     <= C_VSTART;
      r_level     <= C_LVL_ONE;
      r_level_up  <= 1'b0;
      r_game_wrap <= 1'b0;
      r_moved     <= 1'b0;
      r_blocked   <= 1'b0;
    end else if (restart) begin
      r_state     <= S_IDLE;
      r_rpt       <= {RW{1'b0}};
      r_dir_q     <= 4'b0000;
      r_pos_h     <= C_HSTART;
      r_pos_v     <= C_VSTART;
      r_level     <= C_LVL_ONE;
      r_level_up  <= 1'b0;
      r_game_wrap <= 1'b0;
      r_moved     <= 1'b0;
      r_blocked   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rpt       <= w_rpt_nxt;
      r_dir_q     <= w_dir;
      r_moved     <= w_fire & (w_v_chg | w_h_chg);
      r_blocked   <= w_fire & (w_v_ref | w_h_ref);
      r_level_up  <= w_fire & w_adv;
      r_game_wrap <= w_fire & w_adv & w_wrap;
      if (w_fire) begin
        r_pos_h <= w_h_nxt;
        r_pos_v <= w_v_nxt;
      end
      if (w_fire && w_adv) begin
        r_level <= w_lvl_nxt;
      end
    end
  end

  assign pos_h     = r_pos_h;
  assign pos_v     = r_pos_v;
  assign level     = r_level;
  assign level_up  = r_level_up;
  assign game_wrap = r_game_wrap;
  assign moved     = r_moved;
  assign blocked   = r_blocked;

endmodule

// File: tb/tb_player_grid.sv
// Bench for player_grid: directed scenarios plus random traffic, every cycle
// checked against an integer-arithmetic model of the movement rules.
module tb_player_grid;

  localparam int STEP    = 40;
  localparam int H_START = 40;
  localparam int V_START = 240;
  localparam int H_LIMIT = 640;
  localparam int V_LIMIT = 480;
  localparam int RPT     = 4;
  localparam int MAXL    = 15;

  logic       clk;
  logic       reset_player_n;
  logic       restart;
  logic       pause;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic [9:0] pos_h;
  logic [9:0] pos_v;
  logic [3:0] level;
  logic       level_up;
  logic       game_wrap;
  logic       moved;
  logic       blocked;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int         m_h;
  int         m_v;
  int         m_lvl;
  bit         m_hold;
  int         m_cnt;
  logic [3:0] m_prev;
  bit         e_mv;
  bit         e_bl;
  bit         e_lu;
  bit         e_gw;

  player_grid dut (
    .clk            (clk),
    .reset_player_n (reset_player_n),
    .restart        (restart),
    .pause          (pause),
    .up             (up),
    .down           (down),
    .left           (left),
    .right          (right),
    .pos_h          (pos_h),
    .pos_v          (pos_v),
    .level          (level),
    .level_up       (level_up),
    .game_wrap      (game_wrap),
    .moved          (moved),
    .blocked        (blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h = H_START; m_v = V_START; m_lvl = 1;
    m_hold = 1'b0; m_cnt = 0; m_prev = 4'b0000;
    e_mv = 1'b0; e_bl = 1'b0; e_lu = 1'b0; e_gw = 1'b0;
  endtask

  // One clock edge of the movement rules, using the inputs as currently driven
  task automatic model_edge();
    logic [3:0] d;
    bit fire;
    d = {up, down, left, right};
    if (restart) begin
      model_reset();
      return;
    end
    fire = 1'b0;
    if (!pause) begin
      if (!m_hold) begin
        if (d != 4'b0000) begin fire = 1'b1; m_hold = 1'b1; m_cnt = 0; end
      end else if (d == 4'b0000) begin
        m_hold = 1'b0;
      end else if (d != m_prev || m_cnt == RPT - 1) begin
        fire = 1'b1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    m_prev = d;
    e_mv = 1'b0; e_bl = 1'b0; e_lu = 1'b0; e_gw = 1'b0;
    if (fire) begin
      if (up && !down) begin
        if (m_v > STEP) begin m_v -= STEP; e_mv = 1'b1; end else e_bl = 1'b1;
      end else if (down && !up) begin
        if (m_v + STEP < V_LIMIT) begin m_v += STEP; e_mv = 1'b1; end else e_bl = 1'b1;
      end
      if (left && !right) begin
        if (m_h > STEP) begin m_h -= STEP; e_mv = 1'b1; end else e_bl = 1'b1;
      end else if (right && !left) begin
        if (m_h + STEP <= H_LIMIT) begin
          m_h += STEP; e_mv = 1'b1;
        end else begin
          m_h = H_START; e_mv = 1'b1; e_lu = 1'b1;
          if (m_lvl == MAXL) begin m_lvl = 1; e_gw = 1'b1; end else m_lvl++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/pos_h"},     16'(pos_h),     16'(m_h));
    chk({tag, "/pos_v"},     16'(pos_v),     16'(m_v));
    chk({tag, "/level"},     16'(level),     16'(m_lvl));
    chk({tag, "/level_up"},  16'(level_up),  16'(e_lu));
    chk({tag, "/game_wrap"}, 16'(game_wrap), 16'(e_gw));
    chk({tag, "/moved"},     16'(moved),     16'(e_mv));
    chk({tag, "/blocked"},   16'(blocked),   16'(e_bl));
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_dir(input logic [3:0] d);
    {up, down, left, right} = d;
  endtask

  task automatic pulse(input logic [3:0] d, input string tag);
    set_dir(d);
    cycle(tag);
    set_dir(4'b0000);
    cycle({tag, "_rel"});
  endtask

  initial begin
    int n_moves;
    int guard;
    reset_player_n = 1'b0;
    restart = 1'b0;
    pause = 1'b0;
    set_dir(4'b0000);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_all("reset");

    // right held across reset release, then 9 cycles total
    set_dir(4'b0001);
    #2 reset_player_n = 1'b1;
    n_moves = 0;
    for (int i = 0; i < 9; i++) begin
      cycle("hold_right");
      if (moved) n_moves++;
    end
    chk("hold_right_moves", 16'(n_moves), 16'd3);
    chk("hold_right_pos_h", 16'(pos_h), 16'd160);
    set_dir(4'b0000);
    cycle("idle");

    // climb to the top row, then one refused up
    for (int i = 0; i < 5; i++) pulse(4'b1000, "up");
    set_dir(4'b1000);
    cycle("up_edge");
    chk("up_edge_pos_v", 16'(pos_v), 16'd40);
    chk("up_edge_blocked", 16'(blocked), 16'd1);
    set_dir(4'b0000);
    cycle("up_edge_rel");

    // descend to the bottom row, then one refused down
    for (int i = 0; i < 10; i++) pulse(4'b0100, "down");
    set_dir(4'b0100);
    cycle("down_edge");
    chk("down_edge_pos_v", 16'(pos_v), 16'd440);
    chk("down_edge_blocked", 16'(blocked), 16'd1);
    set_dir(4'b0000);
    cycle("down_edge_rel");

    // auto-repeat right until column 640 on level 15
    set_dir(4'b0001);
    guard = 0;
    while (!(m_lvl == MAXL && m_h == H_LIMIT) && guard < 5000) begin
      cycle("climb");
      guard++;
    end
    chk("climb_pos_h", 16'(pos_h), 16'd640);
    chk("climb_level", 16'(level), 16'd15);
    set_dir(4'b0000);
    cycle("climb_rel");
    set_dir(4'b0001);
    cycle("wrap");
    chk("wrap_pos_h", 16'(pos_h), 16'd40);
    chk("wrap_level", 16'(level), 16'd1);
    chk("wrap_level_up", 16'(level_up), 16'd1);
    chk("wrap_game_wrap", 16'(game_wrap), 16'd1);
    chk("wrap_moved", 16'(moved), 16'd1);
    set_dir(4'b0000);
    cycle("wrap_rel");

    // left+right cancel while up moves; up+down cancel entirely
    set_dir(4'b1011);
    cycle("lr_up");
    chk("lr_up_pos_h", 16'(pos_h), 16'd40);
    chk("lr_up_pos_v", 16'(pos_v), 16'd400);
    set_dir(4'b0000);
    cycle("lr_up_rel");
    set_dir(4'b1100);
    cycle("ud");
    chk("ud_pos_v", 16'(pos_v), 16'd400);
    chk("ud_moved", 16'(moved), 16'd0);
    set_dir(4'b0000);
    cycle("ud_rel");

    // pause mid-hold: repeat count frozen, resumes without an extra move
    set_dir(4'b0001);
    for (int i = 0; i < 3; i++) cycle("pre_pause");
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle("paused");
      chk("paused_moved", 16'(moved), 16'd0);
    end
    pause = 1'b0;
    cycle("unpause1");
    chk("unpause1_moved", 16'(moved), 16'd0);
    cycle("unpause2");
    chk("unpause2_moved", 16'(moved), 16'd1);
    chk("unpause2_pos_h", 16'(pos_h), 16'd120);

    // asynchronous reset between edges while holding
    cycle("pre_arst");
    #3 reset_player_n = 1'b0;
    model_reset();
    #1;
    chk("arst_pos_h", 16'(pos_h), 16'd40);
    chk("arst_pos_v", 16'(pos_v), 16'd240);
    chk("arst_level", 16'(level), 16'd1);
    check_all("arst");
    #2 reset_player_n = 1'b1;
    cycle("arst_release");
    chk("arst_release_pos_h", 16'(pos_h), 16'd80);
    set_dir(4'b0100);
    cycle("pre_restart");

    // restart wins over pause and held direction
    restart = 1'b1;
    pause = 1'b1;
    cycle("restart");
    chk("restart_pos_h", 16'(pos_h), 16'd40);
    chk("restart_pos_v", 16'(pos_v), 16'd240);
    chk("restart_level", 16'(level), 16'd1);
    restart = 1'b0;
    pause = 1'b0;

    // random traffic with sticky directions
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) set_dir(4'($urandom_range(0, 15)));
      pause = ($urandom_range(0, 9) == 0);
      restart = ($urandom_range(0, 99) == 0);
      cycle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
